fetch_pc_datapath: RTL and testbench

// - IF-stage datapath of the 5-stage RV32I pipeline: PC select mux, PC register, IF/ID stage registers.
// - Drives the instruction-memory address every cycle; captures {pc, instruction} into IF/ID.
// - Advances only when both memory ports respond and the pipeline is not stalled.
// - A taken redirect (pcmux_sel) loads the target PC and flushes IF/ID.

---
 rtl/fetch_pc_datapath_pkg.sv | 18 +
 rtl/fetch_pc_datapath_load_reg.sv | 35 +++
 rtl/fetch_pc_datapath.sv | 91 +++++++++
 tb/tb_fetch_pc_datapath.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_pc_datapath_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Purpose : shared type and constant definitions for the RV32I pipeline.
//           Holds the machine word type plus the reset PC and the bubble
//           value used to flush pipeline registers.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // First instruction fetched after reset.
    localparam rv32i_word RESET_PC = 32'h0000_0060;

    // Value written into IF/ID on reset or flush.
    localparam rv32i_word BUBBLE   = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_datapath_load_reg.sv
// ---------------------------------------------------------------------------
// load_reg
// Purpose : generic register with a synchronous, priority reset and a load
//           enable. Used for the PC and for both IF/ID registers.
// Ports   : clk    in  1      rising-edge clock
//           reset  in  1      synchronous active-high reset (beats load)
//           load   in  1      capture d on the next edge
//           d      in  WIDTH  next value
//           q      out WIDTH  registered value
// ---------------------------------------------------------------------------
module load_reg
    import rv32i_types::*;
#(
    parameter int        WIDTH     = 32,
    parameter rv32i_word RESET_VAL = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];

    // Reset wins over load so a flush can never be overridden by a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_Q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_datapath.sv
// ---------------------------------------------------------------------------
// fetch_pc_datapath
// Purpose : IF-stage datapath of the 5-stage RV32I pipeline. Selects the next
//           PC, holds the PC register, drives the instruction-memory address
//           and captures {pc, instruction} into the IF/ID registers.
// Ports   : clk            in  1      rising-edge clock
//           reset          in  1      synchronous active-high reset
//           pcmux_sel      in  1      1 = redirect to branch_target + flush
//           branch_target  in  WIDTH  redirect target
//           stall_in       in  1      hold PC and IF/ID
//           resp_a         in  1      instruction-memory response valid
//           resp_b         in  1      data-memory response valid
//           rdata_a        in  WIDTH  instruction word for address_a
//           read_a         out 1      instruction-memory read strobe (always 1)
//           address_a      out WIDTH  instruction-memory address (= PC)
//           pc             out WIDTH  IF/ID registered PC
//           instruction    out WIDTH  IF/ID registered instruction
// ---------------------------------------------------------------------------
module fetch_pc_datapath
    import rv32i_types::*;
#(
    parameter int        WIDTH  = 32,
    parameter rv32i_word RST_PC = RESET_PC,
    parameter rv32i_word BUB    = BUBBLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcmux_sel,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall_in,
    input  logic             resp_a,
    input  logic             resp_b,
    input  logic [WIDTH-1:0] rdata_a,
    output logic             read_a,
    output logic [WIDTH-1:0] address_a,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instruction
);

    logic             w_advance;
    logic             w_ifid_reset;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] r_pc;

    // Both memory ports must be done and no hazard stall pending before the
    // fetch stage moves. The +4 wraps naturally at the word boundary.
    always_comb begin
        w_advance    = resp_a & resp_b & ~stall_in;
        w_pc_next    = pcmux_sel ? branch_target : r_pc + WIDTH'(4);
        w_ifid_reset = reset | pcmux_sel;
    end

    assign read_a    = 1'b1;
    assign address_a = r_pc;

    load_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RST_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (w_advance),
        .d     (w_pc_next),
        .q     (r_pc)
    );

    // A redirect flushes IF/ID even while the PC itself is waiting on memory,
    // so the wrong-path instruction never reaches decode.
    load_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (BUB)
    ) u_ifid_pc_reg (
        .clk   (clk),
        .reset (w_ifid_reset),
        .load  (w_advance),
        .d     (r_pc),
        .q     (pc)
    );

    load_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (BUB)
    ) u_ifid_instr_reg (
        .clk   (clk),
        .reset (w_ifid_reset),
        .load  (w_advance),
        .d     (rdata_a),
        .q     (instruction)
    );

endmodule

// File: tb/tb_fetch_pc_datapath.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_datapath
// Purpose : directed testbench for fetch_pc_datapath. The driver applies one
//           input vector per cycle and pushes the hand-computed post-edge
//           state into a queue; a monitor pops and compares on the falling
//           edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_datapath;

    logic        clk;
    logic        reset;
    logic        pcmuxSel;
    logic [31:0] branchTarget;
    logic        stallIn;
    logic        respA;
    logic        respB;
    logic [31:0] rdataA;
    logic        readA;
    logic [31:0] addressA;
    logic [31:0] pcOut;
    logic [31:0] instrOut;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        string       name;
    } expect_t;

    expect_t expQ[$];
    int      checks   = 0;
    int      failures = 0;

    fetch_pc_datapath dut (
        .clk           (clk),
        .reset         (reset),
        .pcmux_sel     (pcmuxSel),
        .branch_target (branchTarget),
        .stall_in      (stallIn),
        .resp_a        (respA),
        .resp_b        (respB),
        .rdata_a       (rdataA),
        .read_a        (readA),
        .address_a     (addressA),
        .pc            (pcOut),
        .instruction   (instrOut)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and keep the tally.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%08h required=%08h", name, actual, required);
        end
    endtask

    // Monitor: outputs are stable at the falling edge, half a cycle after
    // the edge whose effect the queued entry describes.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput({e.name, ".address_a"}, addressA, e.addr);
            checkOutput({e.name, ".pc"}, pcOut, e.pc);
            checkOutput({e.name, ".instruction"}, instrOut, e.instr);
            checkOutput({e.name, ".read_a"}, {31'd0, readA}, 32'd1);
        end
    end

    // Drive one cycle of inputs, then record what the outputs must be after
    // the next rising edge.
    task automatic applyStimulus(
        input string       name,
        input logic        rst,
        input logic        sel,
        input logic [31:0] tgt,
        input logic        stall,
        input logic        ra,
        input logic        rb,
        input logic [31:0] rdata,
        input logic [31:0] expAddr,
        input logic [31:0] expPc,
        input logic [31:0] expInstr
    );
        expect_t e;
        reset        = rst;
        pcmuxSel     = sel;
        branchTarget = tgt;
        stallIn      = stall;
        respA        = ra;
        respB        = rb;
        rdataA       = rdata;
        @(posedge clk);
        e.addr  = expAddr;
        e.pc    = expPc;
        e.instr = expInstr;
        e.name  = name;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        int waitCycles;
        reset        = 1'b1;
        pcmuxSel     = 1'b0;
        branchTarget = 32'h0;
        stallIn      = 1'b0;
        respA        = 1'b0;
        respB        = 1'b0;
        rdataA       = 32'h0;
        @(negedge clk);

        //            name        rst sel tgt           stl ra rb rdata          addr          pc            instr
        applyStimulus("reset1",    1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h60,       32'h0,        32'h0);
        applyStimulus("reset2",    1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h60,       32'h0,        32'h0);
        applyStimulus("seq0",      0, 0, 32'h0,        0, 1, 1, 32'h00A00093, 32'h64,       32'h60,       32'h00A00093);
        applyStimulus("wait0",     0, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h64,       32'h60,       32'h00A00093);
        applyStimulus("wait1",     0, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h64,       32'h60,       32'h00A00093);
        applyStimulus("wait2",     0, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h64,       32'h60,       32'h00A00093);
        applyStimulus("waitDone",  0, 0, 32'h0,        0, 1, 1, 32'h00100113, 32'h68,       32'h64,       32'h00100113);
        applyStimulus("stall0",    0, 0, 32'h0,        1, 1, 1, 32'h11111111, 32'h68,       32'h64,       32'h00100113);
        applyStimulus("stall1",    0, 0, 32'h0,        1, 1, 1, 32'h22222222, 32'h68,       32'h64,       32'h00100113);
        applyStimulus("unstall",   0, 0, 32'h0,        0, 1, 1, 32'h00200193, 32'h6C,       32'h68,       32'h00200193);
        applyStimulus("redirAdv",  0, 1, 32'h200,      0, 1, 1, 32'hCAFEF00D, 32'h200,      32'h0,        32'h0);
        applyStimulus("seqTgt",    0, 0, 32'h0,        0, 1, 1, 32'h00300213, 32'h204,      32'h200,      32'h00300213);
        applyStimulus("redirHold", 0, 1, 32'h300,      0, 0, 1, 32'hBAD0BAD0, 32'h204,      32'h0,        32'h0);
        applyStimulus("redirGo",   0, 1, 32'h300,      0, 1, 1, 32'hBAD0BAD0, 32'h300,      32'h0,        32'h0);
        applyStimulus("toTop",     0, 1, 32'hFFFFFFFC, 0, 1, 1, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h0);
        applyStimulus("wrap",      0, 0, 32'h0,        0, 1, 1, 32'h00400293, 32'h0,        32'hFFFFFFFC, 32'h00400293);
        applyStimulus("stallFlush",0, 1, 32'h500,      1, 1, 1, 32'h33333333, 32'h0,        32'h0,        32'h0);
        applyStimulus("midReset",  1, 1, 32'h700,      0, 1, 1, 32'h44444444, 32'h60,       32'h0,        32'h0);
        applyStimulus("postReset", 0, 0, 32'h0,        0, 1, 1, 32'h00500313, 32'h64,       32'h60,       32'h00500313);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
